// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
//   Tic-tac-toe game controller fed by the keypad scanner's held key code.
//   A press is accepted after key_data holds the same cell code for
//   DB_CYCLES cycles, and the keypad is re-armed once key_data has been 0 for
//   DB_CYCLES cycles. Each accepted press places one stone for the side to
//   move. After each placement the board is checked for a win or a draw.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   key_data   scanner code: 0 none, 1..9 cell, 10..15 non-cell keys
//   new_game   1-cycle synchronous clear request
//   board      cell k at board[2k-1:2k-2]: 00 empty, 01 X, 10 O
//   turn_o     1 = O to move, 0 = X to move
//   winner     00 none, 01 X, 10 O, 11 draw
//   game_over  high while winner != 00
//   win_line   bit k-1 set for each cell k in a completed line
//   move_ok    1-cycle pulse when a stone is placed
//   move_err   1-cycle pulse when the pressed cell is already occupied
module ttt_game_ctrl #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_data,
  input  logic        new_game,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [8:0]  win_line,
  output logic        move_ok,
  output logic        move_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESS, S_APPLY, S_CHECK, S_RELEASE, S_GAMEOVER
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Cell masks of the 8 lines: rows, columns, diagonals.
  localparam logic [7:0][8:0] LINES = {
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic [17:0]       board_q, board_d;
  logic              turn_q, turn_d;
  logic [1:0]        winner_q, winner_d;
  logic              game_over_q, game_over_d;
  logic [8:0]        win_line_q, win_line_d;
  logic              move_ok_q, move_ok_d;
  logic              move_err_q, move_err_d;

  // Per-cell views of the board and of the latched code.
  logic [8:0] x_cells, o_cells, cell_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign x_cells[gi]  = (board_q[2*gi +: 2] == 2'b01);
      assign o_cells[gi]  = (board_q[2*gi +: 2] == 2'b10);
      assign cell_hit[gi] = (code_q == 4'(gi + 1));
    end
  endgenerate

  // Saturating increment: the debounce counter never wraps.
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  logic       x_win, o_win;
  logic [8:0] lines_done;

  always_comb begin
    x_win      = 1'b0;
    o_win      = 1'b0;
    lines_done = 9'h000;
    for (int l = 0; l < 8; l++) begin
      if ((x_cells & LINES[l]) == LINES[l]) begin
        x_win      = 1'b1;
        lines_done = lines_done | LINES[l];
      end
      if ((o_cells & LINES[l]) == LINES[l]) begin
        o_win      = 1'b1;
        lines_done = lines_done | LINES[l];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    board_d     = board_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    win_line_d  = win_line_q;
    move_ok_d   = 1'b0;
    move_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_data != 4'd0 && key_data <= 4'd9) begin
          code_d  = key_data;
          cnt_d   = '0;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        // The latching cycle in IDLE is the first stable cycle.
        if (key_data == code_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_LAST) state_d = S_APPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        if (|((x_cells | o_cells) & cell_hit)) begin
          move_err_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_RELEASE;
        end else begin
          for (int k = 0; k < 9; k++) begin
            if (cell_hit[k]) board_d[2*k +: 2] = turn_q ? 2'b10 : 2'b01;
          end
          move_ok_d = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d      = '0;
        win_line_d = lines_done;
        if (x_win)                      winner_d = 2'b01;
        else if (o_win)                 winner_d = 2'b10;
        else if (&(x_cells | o_cells))  winner_d = 2'b11;
        else                            turn_d   = ~turn_q;
        game_over_d = (winner_d != 2'b00);
        state_d     = game_over_d ? S_GAMEOVER : S_RELEASE;
      end
      S_RELEASE: begin
        if (key_data != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAMEOVER: ;
      default: state_d = S_IDLE;
    endcase

    // Clear wins over an in-flight APPLY/CHECK; RELEASE stops a held key
    // from being replayed into the fresh game.
    if (new_game) begin
      board_d     = '0;
      turn_d      = 1'b0;
      winner_d    = 2'b00;
      game_over_d = 1'b0;
      win_line_d  = '0;
      move_ok_d   = 1'b0;
      move_err_d  = 1'b0;
      cnt_d       = '0;
      state_d     = S_RELEASE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      board_q     <= '0;
      turn_q      <= 1'b0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      win_line_q  <= '0;
      move_ok_q   <= 1'b0;
      move_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      win_line_q  <= win_line_d;
      move_ok_q   <= move_ok_d;
      move_err_q  <= move_err_d;
    end
  end

  assign board     = board_q;
  assign turn_o    = turn_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;
  assign win_line  = win_line_q;
  assign move_ok   = move_ok_q;
  assign move_err  = move_err_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl
//   Directed bench for ttt_game_ctrl with DB_CYCLES=4. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_data;
  logic        new_game;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  winner;
  logic        game_over;
  logic [8:0]  win_line;
  logic        move_ok;
  logic        move_err;

  int checks   = 0;
  int failures = 0;
  int ok_n, err_n;
  logic [17:0] board_at [1:6];
  logic        turn_at  [1:6];

  ttt_game_ctrl #(.DB_CYCLES(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_data (key_data),
    .new_game (new_game),
    .board    (board),
    .turn_o   (turn_o),
    .winner   (winner),
    .game_over(game_over),
    .win_line (win_line),
    .move_ok  (move_ok),
    .move_err (move_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_board"},  32'(board),     32'h0);
    chk({tag, "_turn"},   32'(turn_o),    32'h0);
    chk({tag, "_winner"}, 32'(winner),    32'h0);
    chk({tag, "_over"},   32'(game_over), 32'h0);
    chk({tag, "_line"},   32'(win_line),  32'h0);
    chk({tag, "_ok"},     32'(move_ok),   32'h0);
    chk({tag, "_err"},    32'(move_err),  32'h0);
  endtask

  // Hold a key 6 cycles then release 6 cycles, counting pulses seen.
  task automatic press(input logic [3:0] k);
    ok_n = 0;
    err_n = 0;
    key_data = k;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ok_n += int'(move_ok);
      err_n += int'(move_err);
      board_at[i] = board;
      turn_at[i] = turn_o;
    end
    key_data = 4'd0;
    repeat (6) begin
      @(negedge clk);
      ok_n += int'(move_ok);
      err_n += int'(move_err);
    end
    $display("press key=%0d ok=%0d err=%0d board=%05h turn=%0d winner=%0d",
             k, ok_n, err_n, board, turn_o, winner);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_data = 4'd0;
    new_game = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic found;
    do_reset();
    chk_zero("reset");

    // Test 1: X wins on the top row; first move also checks latency.
    press(4'd1);
    chk("t1_ok_pulses", 32'(ok_n), 32'd1);
    chk("t1_board_n4", 32'(board_at[4]), 32'h0);
    chk("t1_board_n5", 32'(board_at[5]), 32'h1);
    chk("t1_turn_n5", 32'(turn_at[5]), 32'h0);
    chk("t1_turn_n6", 32'(turn_at[6]), 32'h1);
    press(4'd4);
    press(4'd2);
    press(4'd5);
    press(4'd3);
    chk("t1_winner", 32'(winner), 32'h1);
    chk("t1_over", 32'(game_over), 32'h1);
    chk("t1_line", 32'(win_line), 32'h007);
    chk("t1_board", 32'(board), 32'h00295);
    chk("t1_turn", 32'(turn_o), 32'h0);

    // Test 5: key ignored after game over, then new_game while 6 is held.
    press(4'd6);
    chk("t5_no_ok", 32'(ok_n), 32'd0);
    chk("t5_board_hold", 32'(board), 32'h00295);
    key_data = 4'd6;
    repeat (2) @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk_zero("t5_clear");
    ok_n = 0;
    repeat (10) begin
      @(negedge clk);
      ok_n += int'(move_ok);
    end
    chk("t5_no_replay", 32'(ok_n), 32'd0);
    chk("t5_board_still0", 32'(board), 32'h0);
    key_data = 4'd0;
    repeat (6) @(negedge clk);
    press(4'd6);
    chk("t5_replay_ok", 32'(ok_n), 32'd1);
    chk("t5_board6", 32'(board), 32'h00400);

    // Test 2: pressing an occupied cell.
    do_reset();
    press(4'd5);
    chk("t2_first_ok", 32'(ok_n), 32'd1);
    chk("t2_turn_after", 32'(turn_o), 32'h1);
    press(4'd5);
    chk("t2_err", 32'(err_n), 32'd1);
    chk("t2_no_ok", 32'(ok_n), 32'd0);
    chk("t2_cell5", 32'(board[9:8]), 32'h1);
    chk("t2_board", 32'(board), 32'h00100);
    chk("t2_turn", 32'(turn_o), 32'h1);

    // Test 3: draw.
    do_reset();
    press(4'd1); press(4'd2); press(4'd3);
    press(4'd5); press(4'd4); press(4'd6);
    press(4'd8); press(4'd7); press(4'd9);
    chk("t3_winner", 32'(winner), 32'h3);
    chk("t3_over", 32'(game_over), 32'h1);
    chk("t3_line", 32'(win_line), 32'h0);
    chk("t3_board", 32'(board), 32'h16A59);
    chk("t3_turn", 32'(turn_o), 32'h0);

    // Test 4: bouncing key never places, then a clean press does.
    do_reset();
    ok_n = 0;
    for (int i = 0; i < 10; i++) begin
      key_data = 4'd7;
      repeat (2) begin @(negedge clk); ok_n += int'(move_ok); end
      key_data = 4'd0;
      repeat (2) begin @(negedge clk); ok_n += int'(move_ok); end
    end
    chk("t4_bounce_ok", 32'(ok_n), 32'd0);
    chk("t4_bounce_board", 32'(board), 32'h0);
    press(4'd7);
    chk("t4_clean_ok", 32'(ok_n), 32'd1);
    chk("t4_board7", 32'(board), 32'h01000);

    // Test 6: async reset in PRESS and in CHECK.
    do_reset();
    press(4'd1);
    chk("t6_pre_board", 32'(board), 32'h1);
    key_data = 4'd2;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("t6_rst_press");
    @(negedge clk);
    rst = 1'b0;
    key_data = 4'd0;
    repeat (2) @(negedge clk);
    key_data = 4'd3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (move_ok) found = 1'b1;
    end
    chk("t6_wait_check", 32'(found), 32'h1);
    chk("t6_board_in_check", 32'(board), 32'h10);
    #2 rst = 1'b1;
    #1 chk_zero("t6_rst_check");
    @(negedge clk);
    rst = 1'b0;
    key_data = 4'd0;
    repeat (2) @(negedge clk);
    press(4'd9);
    chk("t6_first_x", 32'(board), 32'h10000);
    chk("t6_turn", 32'(turn_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
